// File: rtl/mmio_confreg.sv
// Memory-mapped LED/switch/scratch/timer register block on the core's SRAM-lite data port.
// Define CONFREG_TIMER_EN to build COUNT/COMPARE/TCTRL and the timer interrupt.
module mmio_confreg #(
    parameter logic [31:0] BASE_ADDR = 32'hBFAF_0000,
    parameter int unsigned LED_W     = 16,
    parameter int unsigned SW_W      = 16
) (
    input  logic              cpu_clk_50M,
    input  logic              cpu_rst_n,
    input  logic              dce,
    input  logic [3:0]        we,
    input  logic [31:0]       daddr,
    input  logic [31:0]       din,
    output logic [31:0]       dm_o,
    output logic              hit_o,
    input  logic [SW_W-1:0]   switch_i,
    output logic [LED_W-1:0]  led_o,
    output logic              timer_int_o
);

    localparam int unsigned IDX_W = 14;
    localparam logic [IDX_W-1:0] IDX_LED     = IDX_W'(0);
    localparam logic [IDX_W-1:0] IDX_SWITCH  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_COUNT   = IDX_W'(2);
    localparam logic [IDX_W-1:0] IDX_COMPARE = IDX_W'(3);
    localparam logic [IDX_W-1:0] IDX_TCTRL   = IDX_W'(4);
    localparam logic [IDX_W-1:0] IDX_SCRATCH = IDX_W'(5);

    // Byte-lane merge of write data into an existing register value.
    function automatic logic [31:0] merge_be(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  be);
        logic [31:0] res;
        res = old_v;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) res[8*i +: 8] = new_v[8*i +: 8];
        end
        return res;
    endfunction

    logic              hit_c, wr_c, rd_c;
    logic [IDX_W-1:0]  idx_c;
    logic [31:0]       rdata_c, led_full_c;
    logic              unused_c;

    logic [LED_W-1:0]  led_q, led_d;
    logic [31:0]       scratch_q, scratch_d;
    logic [31:0]       dm_q, dm_d;
    logic              hit_q, hit_d;
    logic [SW_W-1:0]   sw_meta_q, sw_sync_q;

    assign hit_c    = dce && (daddr[31:16] == BASE_ADDR[31:16]);
    assign idx_c    = daddr[15:2];
    assign wr_c     = hit_c && (we != 4'b0000);
    assign rd_c     = hit_c && (we == 4'b0000);
    assign unused_c = ^daddr[1:0];

`ifdef CONFREG_TIMER_EN
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        tctrl_q, tctrl_d;
    logic        pend_q, pend_d;
    logic        match_c;

    // Match compares pre-update values; a COMPARE write always clears pending.
    always_comb begin
        count_d   = count_q;
        compare_d = compare_q;
        tctrl_d   = tctrl_q;
        match_c   = tctrl_q && (count_q == compare_q);
        if (tctrl_q) count_d = count_q + 32'd1;
        if (wr_c) begin
            case (idx_c)
                IDX_COUNT:   count_d   = merge_be(count_q, din, we);
                IDX_COMPARE: compare_d = merge_be(compare_q, din, we);
                IDX_TCTRL:   if (we[0]) tctrl_d = din[0];
                default: ;
            endcase
        end
        pend_d = pend_q || match_c;
        if (wr_c && (idx_c == IDX_COMPARE)) pend_d = 1'b0;
    end

    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            count_q   <= '0;
            compare_q <= '0;
            tctrl_q   <= 1'b0;
            pend_q    <= 1'b0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            tctrl_q   <= tctrl_d;
            pend_q    <= pend_d;
        end
    end

    assign timer_int_o = pend_q;
`else
    assign timer_int_o = 1'b0;
`endif

    // Read mux; unmapped offsets return zero.
    always_comb begin
        rdata_c = '0;
        case (idx_c)
            IDX_LED:     rdata_c = 32'(led_q);
            IDX_SWITCH:  rdata_c = 32'(sw_sync_q);
`ifdef CONFREG_TIMER_EN
            IDX_COUNT:   rdata_c = count_q;
            IDX_COMPARE: rdata_c = compare_q;
            IDX_TCTRL:   rdata_c = {31'b0, tctrl_q};
`endif
            IDX_SCRATCH: rdata_c = scratch_q;
            default: ;
        endcase
    end

    always_comb begin
        led_full_c = merge_be(32'(led_q), din, we);
        led_d      = led_q;
        scratch_d  = scratch_q;
        if (wr_c) begin
            case (idx_c)
                IDX_LED:     led_d     = led_full_c[LED_W-1:0];
                IDX_SCRATCH: scratch_d = merge_be(scratch_q, din, we);
                default: ;
            endcase
        end
        dm_d  = rd_c ? rdata_c : 32'd0;
        hit_d = hit_c;
    end

    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            led_q     <= '0;
            scratch_q <= '0;
            dm_q      <= '0;
            hit_q     <= 1'b0;
            sw_meta_q <= '0;
            sw_sync_q <= '0;
        end else begin
            led_q     <= led_d;
            scratch_q <= scratch_d;
            dm_q      <= dm_d;
            hit_q     <= hit_d;
            sw_meta_q <= switch_i;
            sw_sync_q <= sw_meta_q;
        end
    end

    assign dm_o  = dm_q;
    assign hit_o = hit_q;
    assign led_o = led_q;

endmodule

// File: tb/tb_mmio_confreg.sv
// Directed self-checking bench for mmio_confreg; timer scenarios follow CONFREG_TIMER_EN.
module tb_mmio_confreg;

    logic        clk;
    logic        rst_n;
    logic        dce;
    logic [3:0]  we;
    logic [31:0] daddr;
    logic [31:0] din;
    logic [31:0] dm_o;
    logic        hit_o;
    logic [15:0] switch_i;
    logic [15:0] led_o;
    logic        timer_int_o;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [31:0] A_LED     = 32'hBFAF_0000;
    localparam logic [31:0] A_SWITCH  = 32'hBFAF_0004;
    localparam logic [31:0] A_COUNT   = 32'hBFAF_0008;
    localparam logic [31:0] A_COMPARE = 32'hBFAF_000C;
    localparam logic [31:0] A_TCTRL   = 32'hBFAF_0010;
    localparam logic [31:0] A_SCRATCH = 32'hBFAF_0014;

    mmio_confreg dut (
        .cpu_clk_50M (clk),
        .cpu_rst_n   (rst_n),
        .dce         (dce),
        .we          (we),
        .daddr       (daddr),
        .din         (din),
        .dm_o        (dm_o),
        .hit_o       (hit_o),
        .switch_i    (switch_i),
        .led_o       (led_o),
        .timer_int_o (timer_int_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One bus cycle: drive request, cross the edge, land 1 time unit after it.
    task automatic cyc(input logic d, input logic [3:0] w, input logic [31:0] a, input logic [31:0] x);
        dce = d; we = w; daddr = a; din = x;
        @(posedge clk);
        #1;
        dce = 1'b0; we = 4'h0; daddr = 32'h0; din = 32'h0;
    endtask

    task automatic test_reset;
        n_cmp++;
        if ({dm_o, hit_o, led_o, timer_int_o} !== 50'd0) begin
            $display("FAIL reset_hold dm=%h hit=%b led=%h int=%b required all 0", dm_o, hit_o, led_o, timer_int_o);
            n_err++;
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        cyc(1, 4'hF, A_LED, 32'h0000_1234);
        cyc(1, 4'h0, A_LED, 32'h0);
        n_cmp++;
        if (dm_o !== 32'h0000_1234) begin
            $display("FAIL pre_reset_read dm=%h required 00001234", dm_o); n_err++;
        end
        dce = 1'b1; we = 4'h0; daddr = A_LED;
        #3;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({dm_o, hit_o, led_o, timer_int_o} !== 50'd0) begin
            $display("FAIL async_reset dm=%h hit=%b led=%h int=%b required all 0", dm_o, hit_o, led_o, timer_int_o);
            n_err++;
        end
        @(posedge clk); #1;
        dce = 1'b0;
        rst_n = 1'b1;
        cyc(1, 4'h0, A_SCRATCH, 32'h0);
        n_cmp++;
        if (dm_o !== 32'h0 || hit_o !== 1'b1) begin
            $display("FAIL post_reset_scratch dm=%h hit=%b required 00000000/1", dm_o, hit_o); n_err++;
        end
        cyc(1, 4'h0, A_LED, 32'h0);
        n_cmp++;
        if (dm_o !== 32'h0) begin
            $display("FAIL post_reset_led dm=%h required 00000000", dm_o); n_err++;
        end
    endtask

    task automatic test_byte_lanes;
        cyc(1, 4'hF, A_SCRATCH, 32'h1122_3344);
        n_cmp++;
        if (hit_o !== 1'b1 || dm_o !== 32'h0) begin
            $display("FAIL write_cycle_out hit=%b dm=%h required 1/00000000", hit_o, dm_o); n_err++;
        end
        cyc(1, 4'b0101, A_SCRATCH, 32'hAABB_CCDD);
        cyc(1, 4'h0, A_SCRATCH, 32'h0);
        n_cmp++;
        if (dm_o !== 32'h11BB_33DD) begin
            $display("FAIL byte_lanes dm=%h required 11BB33DD", dm_o); n_err++;
        end
        cyc(1, 4'b1000, A_SCRATCH, 32'h5500_0000);
        cyc(1, 4'h0, A_SCRATCH, 32'h0);
        n_cmp++;
        if (dm_o !== 32'h55BB_33DD) begin
            $display("FAIL byte_lane3 dm=%h required 55BB33DD", dm_o); n_err++;
        end
    endtask

    task automatic test_decode;
        cyc(0, 4'h0, 32'h0, 32'h0);
        n_cmp++;
        if (dm_o !== 32'h0 || hit_o !== 1'b0) begin
            $display("FAIL idle dm=%h hit=%b required 00000000/0", dm_o, hit_o); n_err++;
        end
        cyc(1, 4'h0, 32'hBFB0_0014, 32'h0);
        n_cmp++;
        if (dm_o !== 32'h0 || hit_o !== 1'b0) begin
            $display("FAIL out_of_window dm=%h hit=%b required 00000000/0", dm_o, hit_o); n_err++;
        end
        cyc(1, 4'hF, 32'hBFB0_0000, 32'h0000_FFFF);
        n_cmp++;
        if (led_o !== 16'h0000 || hit_o !== 1'b0) begin
            $display("FAIL out_of_window_write led=%h hit=%b required 0000/0", led_o, hit_o); n_err++;
        end
        cyc(1, 4'h0, 32'hBFAF_0020, 32'h0);
        n_cmp++;
        if (dm_o !== 32'h0 || hit_o !== 1'b1) begin
            $display("FAIL unmapped_read dm=%h hit=%b required 00000000/1", dm_o, hit_o); n_err++;
        end
        cyc(0, 4'h0, A_SCRATCH, 32'h0);
        n_cmp++;
        if (hit_o !== 1'b0) begin
            $display("FAIL dce_low hit=%b required 0", hit_o); n_err++;
        end
        cyc(1, 4'hF, A_LED, 32'hFFFF_A5A5);
        n_cmp++;
        if (led_o !== 16'hA5A5) begin
            $display("FAIL led_write led=%h required A5A5", led_o); n_err++;
        end
        cyc(1, 4'h0, A_LED | 32'h3, 32'h0);
        n_cmp++;
        if (dm_o !== 32'h0000_A5A5) begin
            $display("FAIL led_read dm=%h required 0000A5A5", dm_o); n_err++;
        end
    endtask

    task automatic test_switch;
        logic [31:0] exp_sw [4];
        exp_sw[0] = 32'h0; exp_sw[1] = 32'h0; exp_sw[2] = 32'h0000_00F0; exp_sw[3] = 32'h0000_00F0;
        switch_i = 16'h00F0;
        for (int i = 0; i < 4; i++) begin
            cyc(1, 4'h0, A_SWITCH, 32'h0);
            n_cmp++;
            if (dm_o !== exp_sw[i]) begin
                $display("FAIL switch_sync_%0d dm=%h required %h", i, dm_o, exp_sw[i]); n_err++;
            end
        end
        cyc(1, 4'hF, A_SWITCH, 32'hFFFF_FFFF);
        cyc(1, 4'h0, A_SWITCH, 32'h0);
        n_cmp++;
        if (dm_o !== 32'h0000_00F0) begin
            $display("FAIL switch_ro dm=%h required 000000F0", dm_o); n_err++;
        end
    endtask

    task automatic test_back_to_back;
        cyc(1, 4'hF, A_SCRATCH, 32'hCAFE_0001);
        cyc(1, 4'h0, A_SCRATCH, 32'h0);
        n_cmp++;
        if (dm_o !== 32'hCAFE_0001) begin
            $display("FAIL b2b_first dm=%h required CAFE0001", dm_o); n_err++;
        end
        cyc(1, 4'hF, A_LED, 32'h0000_0F0F);
        cyc(1, 4'h0, A_LED, 32'h0);
        n_cmp++;
        if (dm_o !== 32'h0000_0F0F) begin
            $display("FAIL b2b_led dm=%h required 00000F0F", dm_o); n_err++;
        end
        cyc(1, 4'h0, A_SCRATCH, 32'h0);
        n_cmp++;
        if (dm_o !== 32'hCAFE_0001) begin
            $display("FAIL b2b_second dm=%h required CAFE0001", dm_o); n_err++;
        end
    endtask

`ifdef CONFREG_TIMER_EN
    task automatic test_timer;
        cyc(1, 4'hF, A_COMPARE, 32'd5);
        cyc(1, 4'hF, A_COUNT, 32'd0);
        cyc(1, 4'hF, A_TCTRL, 32'd1);
        for (int i = 1; i <= 5; i++) cyc(0, 4'h0, 32'h0, 32'h0);
        n_cmp++;
        if (timer_int_o !== 1'b0) begin
            $display("FAIL int_early int=%b required 0", timer_int_o); n_err++;
        end
        cyc(0, 4'h0, 32'h0, 32'h0);
        n_cmp++;
        if (timer_int_o !== 1'b1) begin
            $display("FAIL int_rise int=%b required 1", timer_int_o); n_err++;
        end
        cyc(1, 4'h0, A_COUNT, 32'h0);
        n_cmp++;
        if (dm_o !== 32'd6) begin
            $display("FAIL count_after_match dm=%h required 00000006", dm_o); n_err++;
        end
        cyc(1, 4'hF, A_COUNT, 32'hFFFF_FFFF);
        cyc(1, 4'h0, A_COUNT, 32'h0);
        cyc(1, 4'h0, A_COUNT, 32'h0);
        n_cmp++;
        if (dm_o !== 32'h0 || timer_int_o !== 1'b1) begin
            $display("FAIL int_sticky_wrap dm=%h int=%b required 00000000/1", dm_o, timer_int_o); n_err++;
        end
        cyc(1, 4'hF, A_COUNT, 32'd4);
        cyc(0, 4'h0, 32'h0, 32'h0);
        cyc(1, 4'hF, A_COMPARE, 32'h100);
        n_cmp++;
        if (timer_int_o !== 1'b0) begin
            $display("FAIL clear_wins int=%b required 0", timer_int_o); n_err++;
        end
        cyc(0, 4'h0, 32'h0, 32'h0);
        n_cmp++;
        if (timer_int_o !== 1'b0) begin
            $display("FAIL clear_holds int=%b required 0", timer_int_o); n_err++;
        end
    endtask

    task automatic test_wrap_override;
        logic [31:0] exp_c [3];
        exp_c[0] = 32'hFFFF_FFFE; exp_c[1] = 32'hFFFF_FFFF; exp_c[2] = 32'h0;
        cyc(1, 4'hF, A_TCTRL, 32'd0);
        cyc(1, 4'hF, A_COMPARE, 32'hDEAD_BEEF);
        cyc(1, 4'hF, A_COUNT, 32'hFFFF_FFFE);
        cyc(1, 4'hF, A_TCTRL, 32'd1);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 4'h0, A_COUNT, 32'h0);
            n_cmp++;
            if (dm_o !== exp_c[i]) begin
                $display("FAIL wrap_%0d dm=%h required %h", i, dm_o, exp_c[i]); n_err++;
            end
        end
        cyc(1, 4'hF, A_COUNT, 32'h100);
        cyc(1, 4'h0, A_COUNT, 32'h0);
        n_cmp++;
        if (dm_o !== 32'h100) begin
            $display("FAIL override dm=%h required 00000100", dm_o); n_err++;
        end
        cyc(0, 4'h0, 32'h0, 32'h0);
        cyc(1, 4'h0, A_COUNT, 32'h0);
        n_cmp++;
        if (dm_o !== 32'h102) begin
            $display("FAIL override_run dm=%h required 00000102", dm_o); n_err++;
        end
        cyc(1, 4'hF, A_TCTRL, 32'hFFFF_FFFF);
        cyc(1, 4'h0, A_TCTRL, 32'h0);
        n_cmp++;
        if (dm_o !== 32'h1 || timer_int_o !== 1'b0) begin
            $display("FAIL tctrl_read dm=%h int=%b required 00000001/0", dm_o, timer_int_o); n_err++;
        end
    endtask
`else
    task automatic test_timer_absent;
        cyc(1, 4'hF, A_COUNT, 32'hFFFF_FFFF);
        cyc(1, 4'hF, A_COMPARE, 32'h0);
        cyc(1, 4'hF, A_TCTRL, 32'h1);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 4'h0, A_COUNT + 32'(4 * i), 32'h0);
            n_cmp++;
            if (dm_o !== 32'h0 || hit_o !== 1'b1) begin
                $display("FAIL timer_unmapped_%0d dm=%h hit=%b required 00000000/1", i, dm_o, hit_o); n_err++;
            end
        end
        n_cmp++;
        if (timer_int_o !== 1'b0) begin
            $display("FAIL timer_int_tied int=%b required 0", timer_int_o); n_err++;
        end
    endtask
`endif

    initial begin
        rst_n = 1'b0; dce = 1'b0; we = 4'h0; daddr = 32'h0; din = 32'h0; switch_i = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        test_reset;
        test_byte_lanes;
        test_decode;
        test_switch;
        test_back_to_back;
`ifdef CONFREG_TIMER_EN
        test_timer;
        test_wrap_override;
`else
        test_timer_absent;
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
